mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Latency: grant 1 cycle after request, ack 1 cycle after mem_ready (minimum 2 cycles req->ack).
// Backpressure: requests are held until ack; stall covers the wait; mem_ready stretches BUSY up to TIMEOUT cycles.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [8:0]  TMO = TIMEOUT[8:0];
    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t     state;
    logic       grant_d;
    logic       last_grant;
    logic       pick_d;
    logic [8:0] wait_cnt;
    logic [8:0] wait_nxt;

    always_comb begin
        pick_d   = (if_req && d_req) ? ~last_grant : d_req;
        wait_nxt = wait_cnt + 9'd1;
    end

    assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_d    <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state      <= BUSY;
                        grant_d    <= pick_d;
                        last_grant <= pick_d;
                        wait_cnt   <= '0;
                        mem_req    <= 1'b1;
                        mem_addr   <= pick_d ? d_addr : if_addr;
                        mem_we     <= pick_d & d_we;
                        mem_wdata  <= pick_d ? d_wdata : '0;
                    end
                end
                BUSY: begin
                    // mem_ready wins over a timeout landing in the same cycle
                    if (mem_ready) begin
                        if (grant_d) d_rdata  <= mem_rdata;
                        else         if_rdata <= mem_rdata;
                        d_ack   <= grant_d;
                        if_ack  <= ~grant_d;
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end else if (wait_nxt == TMO) begin
                        if (grant_d) d_rdata  <= NOP;
                        else         if_rdata <= NOP;
                        err      <= 1'b1;
                        d_ack    <= grant_d;
                        if_ack   <= ~grant_d;
                        mem_req  <= 1'b0;
                        wait_cnt <= wait_nxt;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                RESP: begin
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
